pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// State encodings, the default divide timeout and the hold/jump enable levels live here.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_JUMP_PEND = 2'd2
  } state_e;

  localparam int unsigned DIV_TIMEOUT_DEF = 40;
  localparam int          CNT_W           = 6;

  localparam logic HOLD_ENA = 1'b1;
  localparam logic JUMP_ENA = 1'b1;

  // Wait counter stops at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags a load in EX whose destination feeds an enabled ID source.
module hazard_detect (
  input  logic       mem_r_ena_i,
  input  logic [4:0] w_addr_i,
  input  logic [4:0] r1_addr_i,
  input  logic [4:0] r2_addr_i,
  input  logic       r1_ena_i,
  input  logic       r2_ena_i,
  output logic       load_use_o
);

  logic r1_hit;
  logic r2_hit;

  assign r1_hit = r1_ena_i && (r1_addr_i == w_addr_i);
  assign r2_hit = r2_ena_i && (r2_addr_i == w_addr_i);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = mem_r_ena_i && (w_addr_i != 5'd0) && (r1_hit || r2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: divide stall FSM, bus-hold stalls, jump redirect/flush and load-use bubbles.
// All outputs except div_timeout_o are combinational from the state and the current inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic        clk_100MHz,
  input  logic        arst,
  input  logic        ex_mem_r_ena_i,
  input  logic [4:0]  ex_reg_w_addr_i,
  input  logic [4:0]  id_reg1_r_addr_i,
  input  logic [4:0]  id_reg2_r_addr_i,
  input  logic        id_reg1_r_ena_i,
  input  logic        id_reg2_r_ena_i,
  input  logic        ex_jump_ena_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_div_start_i,
  input  logic        div_ready_i,
  input  logic        bus_hold_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_ena_o,
  output logic [31:0] jump_addr_o,
  output logic        div_busy_o,
  output logic        div_timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(DIV_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic hold_all;
  logic lu_stall;
  logic flush_jump;

  hazard_detect u_hazard_detect (
    .mem_r_ena_i (ex_mem_r_ena_i),
    .w_addr_i    (ex_reg_w_addr_i),
    .r1_addr_i   (id_reg1_r_addr_i),
    .r2_addr_i   (id_reg2_r_addr_i),
    .r1_ena_i    (id_reg1_r_ena_i),
    .r2_ena_i    (id_reg2_r_ena_i),
    .load_use_o  (load_use)
  );

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_addr_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    timeout_d   = timeout_q;
    hold_all    = 1'b0;
    lu_stall    = 1'b0;
    flush_jump  = 1'b0;
    jump_ena_o  = 1'b0;
    jump_addr_o = '0;
    div_busy_o  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        // A divide that completes in its issue cycle needs no stall and masks everything below it.
        if (ex_div_start_i) begin
          if (!div_ready_i) begin
            hold_all = HOLD_ENA;
            cnt_d    = '0;
            state_d  = ST_DIV_WAIT;
          end
        end else if (bus_hold_i) begin
          hold_all = HOLD_ENA;
          if (ex_jump_ena_i) begin
            pend_addr_d = ex_jump_addr_i;
            state_d     = ST_JUMP_PEND;
          end
        end else if (ex_jump_ena_i) begin
          jump_ena_o  = JUMP_ENA;
          jump_addr_o = ex_jump_addr_i;
          flush_jump  = 1'b1;
        end else if (load_use) begin
          lu_stall = 1'b1;
        end
      end

      ST_DIV_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        // Completion (result or abort) drops the divide stall but a bus stall still wins.
        if (div_ready_i) begin
          hold_all = bus_hold_i;
          state_d  = ST_RUN;
        end else if (cnt_q == TIMEOUT_CNT) begin
          hold_all  = bus_hold_i;
          timeout_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          hold_all   = HOLD_ENA;
          div_busy_o = 1'b1;
        end
      end

      ST_JUMP_PEND: begin
        if (bus_hold_i) begin
          hold_all = HOLD_ENA;
        end else begin
          jump_ena_o  = JUMP_ENA;
          jump_addr_o = pend_addr_q;
          flush_jump  = 1'b1;
          state_d     = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign hold_pc_o     = hold_all | lu_stall;
  assign hold_if_id_o  = hold_all | lu_stall;
  assign hold_id_ex_o  = hold_all;
  assign flush_if_id_o = flush_jump;
  assign flush_id_ex_o = flush_jump | lu_stall;
  assign div_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: expected outputs are queued with each stimulus
// and popped when the outputs are sampled mid-cycle.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        memR;
    logic [4:0]  wAddr;
    logic [4:0]  r1Addr;
    logic [4:0]  r2Addr;
    logic        r1Ena;
    logic        r2Ena;
    logic        jmp;
    logic [31:0] jAddr;
    logic        divStart;
    logic        divReady;
    logic        busHold;
  } stim_t;

  // Flag order: holdPc, holdIfId, holdIdEx, flushIfId, flushIdEx, jumpEna, divBusy, divTimeout.
  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] jumpAddr;
  } exp_t;

  localparam logic [7:0] F_NONE  = 8'b0000_0000;
  localparam logic [7:0] F_HOLD3 = 8'b1110_0000;
  localparam logic [7:0] F_LU    = 8'b1100_1000;
  localparam logic [7:0] F_JMP   = 8'b0001_1100;
  localparam logic [7:0] F_WAIT  = 8'b1110_0010;
  localparam logic [7:0] F_TO    = 8'b0000_0001;

  logic        clk;
  logic        arst;
  logic        exMemREna;
  logic [4:0]  exRegWAddr;
  logic [4:0]  idReg1RAddr;
  logic [4:0]  idReg2RAddr;
  logic        idReg1REna;
  logic        idReg2REna;
  logic        exJumpEna;
  logic [31:0] exJumpAddr;
  logic        exDivStart;
  logic        divReady;
  logic        busHold;
  logic        holdPc;
  logic        holdIfId;
  logic        holdIdEx;
  logic        flushIfId;
  logic        flushIdEx;
  logic        jumpEna;
  logic [31:0] jumpAddr;
  logic        divBusy;
  logic        divTimeout;

  exp_t  expQ[$];
  int    checks = 0;
  int    passes = 0;
  stim_t s;

  pipe_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk_100MHz       (clk),
    .arst             (arst),
    .ex_mem_r_ena_i   (exMemREna),
    .ex_reg_w_addr_i  (exRegWAddr),
    .id_reg1_r_addr_i (idReg1RAddr),
    .id_reg2_r_addr_i (idReg2RAddr),
    .id_reg1_r_ena_i  (idReg1REna),
    .id_reg2_r_ena_i  (idReg2REna),
    .ex_jump_ena_i    (exJumpEna),
    .ex_jump_addr_i   (exJumpAddr),
    .ex_div_start_i   (exDivStart),
    .div_ready_i      (divReady),
    .bus_hold_i       (busHold),
    .hold_pc_o        (holdPc),
    .hold_if_id_o     (holdIfId),
    .hold_id_ex_o     (holdIdEx),
    .flush_if_id_o    (flushIfId),
    .flush_id_ex_o    (flushIdEx),
    .jump_ena_o       (jumpEna),
    .jump_addr_o      (jumpAddr),
    .div_busy_o       (divBusy),
    .div_timeout_o    (divTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    return '0;
  endfunction

  function automatic exp_t mkExp(input logic [7:0] f, input logic [31:0] a);
    return {f, a};
  endfunction

  task automatic applyStimulus(input stim_t st, input exp_t e);
    exMemREna   = st.memR;
    exRegWAddr  = st.wAddr;
    idReg1RAddr = st.r1Addr;
    idReg2RAddr = st.r2Addr;
    idReg1REna  = st.r1Ena;
    idReg2REna  = st.r2Ena;
    exJumpEna   = st.jmp;
    exJumpAddr  = st.jAddr;
    exDivStart  = st.divStart;
    divReady    = st.divReady;
    busHold     = st.busHold;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t obs;
    exp_t e;
    @(negedge clk);
    obs = {holdPc, holdIfId, holdIdEx, flushIfId, flushIdEx, jumpEna, divBusy, divTimeout, jumpAddr};
    checks++;
    if (expQ.size() == 0) begin
      $error("[TB] FAIL %s: observed=%h with no expected entry queued", tag, obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e) passes++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input stim_t st, input logic [7:0] f, input logic [31:0] a, input string tag);
    applyStimulus(st, mkExp(f, a));
    checkOutput(tag);
  endtask

  function automatic stim_t luStim(input logic [4:0] w, input logic [4:0] r1, input logic e1,
                                   input logic [4:0] r2, input logic e2);
    stim_t t;
    t        = '0;
    t.memR   = 1'b1;
    t.wAddr  = w;
    t.r1Addr = r1;
    t.r1Ena  = e1;
    t.r2Addr = r2;
    t.r2Ena  = e2;
    return t;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end within 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst = 1'b1;
    step(idle(), F_NONE, 32'h0, "reset_state");
    arst = 1'b0;

    // Load-use hazards and non-hazards
    step(luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), F_LU, 32'h0, "lu_x5_reg1");
    step(idle(), F_NONE, 32'h0, "lu_x5_after");
    step(luStim(5'd12, 5'd3, 1'b1, 5'd12, 1'b1), F_LU, 32'h0, "lu_x12_reg2");
    step(luStim(5'd12, 5'd3, 1'b1, 5'd12, 1'b0), F_NONE, 32'h0, "lu_reg2_disabled");
    step(luStim(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), F_NONE, 32'h0, "lu_x0");
    step(luStim(5'd5, 5'd6, 1'b1, 5'd7, 1'b1), F_NONE, 32'h0, "lu_no_match");
    s = luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    s.memR = 1'b0;
    step(s, F_NONE, 32'h0, "lu_not_load");

    // Jump addr must read 0 while jump is not enabled
    s = idle();
    s.jAddr = 32'hFFFF_FFFF;
    step(s, F_NONE, 32'h0, "jaddr_gated");

    // Jump overrides a simultaneous load-use
    s = luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    s.jmp = 1'b1;
    s.jAddr = 32'hDEAD_BEE0;
    step(s, F_JMP, 32'hDEAD_BEE0, "jump_run");
    step(idle(), F_NONE, 32'h0, "jump_after");

    // Divide with ready after 7 wait cycles; a jump on the start cycle is ignored
    s = idle();
    s.divStart = 1'b1;
    s.jmp = 1'b1;
    s.jAddr = 32'h0000_4000;
    step(s, F_HOLD3, 32'h0, "div7_start");
    for (int i = 0; i < 7; i++) step(idle(), F_WAIT, 32'h0, "div7_wait");
    s = idle();
    s.divReady = 1'b1;
    step(s, F_NONE, 32'h0, "div7_ready");
    step(luStim(5'd9, 5'd9, 1'b1, 5'd0, 1'b0), F_LU, 32'h0, "div7_back_in_run");

    // Divide finishing in its issue cycle
    s = idle();
    s.divStart = 1'b1;
    s.divReady = 1'b1;
    step(s, F_NONE, 32'h0, "div_instant");
    step(luStim(5'd9, 5'd0, 1'b0, 5'd9, 1'b1), F_LU, 32'h0, "div_instant_run");

    // Ready while the bus stalls keeps the holds, then back to RUN
    s = idle();
    s.divStart = 1'b1;
    step(s, F_HOLD3, 32'h0, "divbus_start");
    step(idle(), F_WAIT, 32'h0, "divbus_wait");
    s = idle();
    s.divReady = 1'b1;
    s.busHold = 1'b1;
    step(s, F_HOLD3, 32'h0, "divbus_ready_held");
    step(idle(), F_NONE, 32'h0, "divbus_after");

    // Bus hold in RUN beats load-use
    s = luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    s.busHold = 1'b1;
    step(s, F_HOLD3, 32'h0, "bus_hold_run");

    // Jump to 0x100 during a 3-cycle bus hold
    s = idle();
    s.busHold = 1'b1;
    s.jmp = 1'b1;
    s.jAddr = 32'h0000_0100;
    step(s, F_HOLD3, 32'h0, "jpend_hold1");
    s = idle();
    s.busHold = 1'b1;
    step(s, F_HOLD3, 32'h0, "jpend_hold2");
    step(s, F_HOLD3, 32'h0, "jpend_hold3");
    step(idle(), F_JMP, 32'h0000_0100, "jpend_release");
    step(idle(), F_NONE, 32'h0, "jpend_after");

    // Reset in the middle of DIV_WAIT
    s = idle();
    s.divStart = 1'b1;
    step(s, F_HOLD3, 32'h0, "rstdiv_start");
    step(idle(), F_WAIT, 32'h0, "rstdiv_wait");
    arst = 1'b1;
    step(idle(), F_NONE, 32'h0, "rstdiv_in_reset");
    arst = 1'b0;
    step(idle(), F_NONE, 32'h0, "rstdiv_after");
    step(luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), F_LU, 32'h0, "rstdiv_run");

    // Reset in the middle of JUMP_PEND loses the pending jump
    s = idle();
    s.busHold = 1'b1;
    s.jmp = 1'b1;
    s.jAddr = 32'h0000_0200;
    step(s, F_HOLD3, 32'h0, "rstjp_latch");
    arst = 1'b1;
    step(idle(), F_NONE, 32'h0, "rstjp_in_reset");
    arst = 1'b0;
    step(idle(), F_NONE, 32'h0, "rstjp_no_jump");

    // Divide timeout after 40 DIV_WAIT cycles; flag is sticky until reset
    s = idle();
    s.divStart = 1'b1;
    step(s, F_HOLD3, 32'h0, "to_start");
    for (int i = 0; i < 39; i++) step(idle(), F_WAIT, 32'h0, "to_wait");
    step(idle(), F_NONE, 32'h0, "to_abort_cycle");
    step(idle(), F_TO, 32'h0, "to_flag_set");
    step(luStim(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), F_LU | F_TO, 32'h0, "to_run_lu");
    s = idle();
    s.divStart = 1'b1;
    s.divReady = 1'b1;
    step(s, F_TO, 32'h0, "to_sticky_div");
    step(idle(), F_TO, 32'h0, "to_sticky_idle");
    arst = 1'b1;
    step(idle(), F_NONE, 32'h0, "to_cleared_by_reset");
    arst = 1'b0;
    step(idle(), F_NONE, 32'h0, "to_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
